// File: rtl/lane_combine_pipe.sv
// lane_combine_pipe: per-lane inverter/OAI222 combine into a 2-entry elastic buffer.
// Optional LANE_COMBINE_PIPE_PARITY_EN adds registered per-lane parity on out_parity.
module lane_combine_pipe #(
  parameter int LANES   = 3,
  parameter int GROUPS  = 3,
  parameter int COUNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*4*GROUPS-1:0] in_a,
  input  logic [LANES*4*GROUPS-1:0] in_b,
  input  logic [LANES-1:0]          in_mask,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*4*GROUPS-1:0] out_c,
`ifdef LANE_COMBINE_PIPE_PARITY_EN
  output logic [LANES-1:0]          out_parity,
`endif
  output logic [COUNT_W-1:0]        out_count
);

  localparam int LW = 4 * GROUPS;
  localparam int W  = LANES * LW;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nx;
  logic [W-1:0] word;
  logic [W-1:0] e0;
  logic [W-1:0] e1;
  logic [3:0]   ga;
  logic [3:0]   gb;
  logic         rdy_q;
  logic         push;
  logic         pop;

  always_comb begin
    word = '0;
    ga   = '0;
    gb   = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int g = 0; g < GROUPS; g++) begin
        ga = in_a[l*LW+4*g +: 4];
        gb = in_b[l*LW+4*g +: 4];
        if (in_mask[l]) begin
          word[l*LW+4*g +: 4] = {
            ~((ga[1] | ga[2]) & (gb[1] | gb[2]) & (ga[3] | gb[3])),
            ~gb[1], ~gb[0], ~ga[0]};
        end
      end
    end
  end

  // rst must block acceptance in the very cycle it rises
  assign in_ready = rdy_q & ~rst;
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      rdy_q <= 1'b1;
    end else begin
      state <= state_nx;
      rdy_q <= (state_nx != TWO);
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      EMPTY: if (push) state_nx = ONE;
      ONE: begin
        if (push && !pop)      state_nx = TWO;
        else if (pop && !push) state_nx = EMPTY;
      end
      TWO:   if (pop) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state != EMPTY);
    out_c     = e0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e0 <= '0;
      e1 <= '0;
    end else begin
      unique case (state)
        EMPTY: if (push) e0 <= word;
        ONE: begin
          if (push && pop) e0 <= word;
          else if (push)   e1 <= word;
        end
        TWO:   if (pop) e0 <= e1;
        default: ;
      endcase
    end
  end

`ifdef LANE_COMBINE_PIPE_PARITY_EN
  logic [LANES-1:0] par_w;
  logic [LANES-1:0] p0;
  logic [LANES-1:0] p1;

  always_comb begin
    par_w = '0;
    for (int l = 0; l < LANES; l++) begin
      par_w[l] = ^word[l*LW +: LW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p0 <= '0;
      p1 <= '0;
    end else begin
      unique case (state)
        EMPTY: if (push) p0 <= par_w;
        ONE: begin
          if (push && pop) p0 <= par_w;
          else if (push)   p1 <= par_w;
        end
        TWO:   if (pop) p0 <= p1;
        default: ;
      endcase
    end
  end

  assign out_parity = p0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_count <= '0;
    end else if (pop && (out_count != '1)) begin
      out_count <= out_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_lane_combine_pipe.sv
// tb_lane_combine_pipe: scoreboard bench for lane_combine_pipe.
// Parity checks run only when LANE_COMBINE_PIPE_PARITY_EN is defined.
module tb_lane_combine_pipe;

  localparam int LANES   = 3;
  localparam int GROUPS  = 3;
  localparam int COUNT_W = 8;
  localparam int LW      = 4 * GROUPS;
  localparam int W       = LANES * LW;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       in_a;
  logic [W-1:0]       in_b;
  logic [LANES-1:0]   in_mask;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       out_c;
  logic [COUNT_W-1:0] out_count;
`ifdef LANE_COMBINE_PIPE_PARITY_EN
  logic [LANES-1:0]   out_parity;
`endif

  int total = 0;
  int bad   = 0;
  logic [W-1:0] sb[$];

  lane_combine_pipe #(
    .LANES(LANES),
    .GROUPS(GROUPS),
    .COUNT_W(COUNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_mask(in_mask),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_c(out_c),
`ifdef LANE_COMBINE_PIPE_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  // De Morgan form of the OAI222 bit, independent of the RTL expression
  function automatic logic [W-1:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic [LANES-1:0] m);
    logic [W-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int g = 0; g < GROUPS; g++) begin
        int o;
        o = l * LW + 4 * g;
        if (m[l]) begin
          r[o]   = !a[o];
          r[o+1] = !b[o];
          r[o+2] = !b[o+1];
          r[o+3] = (!a[o+1] && !a[o+2]) || (!b[o+1] && !b[o+2])
                   || (!a[o+3] && !b[o+3]);
        end
      end
    end
    return r;
  endfunction

  task automatic rand_in();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    in_a = r[W-1:0];
    r = {$urandom(), $urandom()};
    in_b = r[W-1:0];
    in_mask = 3'($urandom_range(0, 7));
  endtask

  task automatic tick(output bit popped, output logic [W-1:0] got,
                      output logic [W-1:0] exp);
    popped = 1'b0;
    got = '0;
    exp = '0;
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      popped = 1'b1;
      got = out_c;
      if (sb.size() > 0) exp = sb.pop_front();
      else exp = 'x;
    end
    if (!rst && in_valid && in_ready) sb.push_back(model(in_a, in_b, in_mask));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit p;
    logic [W-1:0] g, e;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_mask = '1;
    out_ready = 1'b0;
    tick(p, g, e);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_in_ready got=%b exp=0", in_ready);
    end
    tick(p, g, e);
    total++;
    if (out_valid !== 1'b0 || out_c !== '0 || out_count !== '0) begin
      bad++;
      $display("FAIL rst_state valid=%b c=%h cnt=%0d exp 0/0/0",
               out_valid, out_c, out_count);
    end
    rst = 1'b0;
    tick(p, g, e);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_release in_ready=%b valid=%b exp 1/0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_function();
    bit p;
    logic [W-1:0] g, e;
    logic [3:0] av[3] = '{4'h0, 4'hF, 4'hE};
    logic [3:0] bv[3] = '{4'h0, 4'hF, 4'h1};
    logic [3:0] cv[3] = '{4'hF, 4'h0, 4'hD};
    out_ready = 1'b1;
    in_mask = '1;
    for (int i = 0; i < 3; i++) begin
      in_a = {(W/4){av[i]}};
      in_b = {(W/4){bv[i]}};
      in_valid = 1'b1;
      tick(p, g, e);
      if (p) begin
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL fn_pop got=%h exp=%h", g, e);
        end
      end
      total++;
      if (out_valid !== 1'b1 || out_c !== {(W/4){cv[i]}}) begin
        bad++;
        $display("FAIL fn_word%0d valid=%b got=%h exp=%h",
                 i, out_valid, out_c, {(W/4){cv[i]}});
      end
    end
    in_valid = 1'b0;
    tick(p, g, e);
    total++;
    if (!p || g !== e || out_count !== 8'd3) begin
      bad++;
      $display("FAIL fn_last popped=%b got=%h exp=%h cnt=%0d exp 3",
               p, g, e, out_count);
    end
  endtask

  task automatic test_mask();
    bit p;
    logic [W-1:0] g, e;
    in_a = '0;
    in_b = '0;
    in_mask = 3'b010;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick(p, g, e);
    in_valid = 1'b0;
    total++;
    if (out_c !== 36'h000_FFF_000) begin
      bad++;
      $display("FAIL mask got=%h exp=%h", out_c, 36'h000_FFF_000);
    end
    tick(p, g, e);
    total++;
    if (!p || g !== e) begin
      bad++;
      $display("FAIL mask_pop popped=%b got=%h exp=%h", p, g, e);
    end
  endtask

  task automatic test_backpressure();
    bit p;
    logic [W-1:0] g, e, w1;
    out_ready = 1'b0;
    rand_in();
    w1 = model(in_a, in_b, in_mask);
    in_valid = 1'b1;
    tick(p, g, e);
    rand_in();
    tick(p, g, e);
    total++;
    if (in_ready !== 1'b0 || sb.size() != 2) begin
      bad++;
      $display("FAIL bp_full in_ready=%b exp=0 queued=%0d", in_ready, sb.size());
    end
    rand_in();
    for (int i = 0; i < 3; i++) begin
      tick(p, g, e);
      total++;
      if (out_c !== w1 || out_valid !== 1'b1 || p) begin
        bad++;
        $display("FAIL bp_stall got=%h exp=%h valid=%b", out_c, w1, out_valid);
      end
    end
    total++;
    if (sb.size() != 2) begin
      bad++;
      $display("FAIL bp_held queued=%0d exp=2", sb.size());
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) in_valid = 1'b0;
      tick(p, g, e);
      total++;
      if (!p || g !== e) begin
        bad++;
        $display("FAIL bp_order%0d popped=%b got=%h exp=%h", i, p, g, e);
      end
      if (i == 0) begin
        total++;
        if (in_ready !== 1'b1) begin
          bad++;
          $display("FAIL bp_reopen in_ready=%b exp=1", in_ready);
        end
      end
    end
    total++;
    if (sb.size() != 0 || out_valid !== 1'b0 || out_count !== 8'd7) begin
      bad++;
      $display("FAIL bp_drain queued=%0d valid=%b cnt=%0d exp 0/0/7",
               sb.size(), out_valid, out_count);
    end
  endtask

  task automatic test_saturation();
    bit p;
    logic [W-1:0] g, e;
    int errs;
    errs = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      rand_in();
      tick(p, g, e);
      if (p && g !== e) errs++;
    end
    in_valid = 1'b0;
    tick(p, g, e);
    if (p && g !== e) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL sat_data errors=%0d exp=0", errs);
    end
    total++;
    if (out_count !== 8'hFF) begin
      bad++;
      $display("FAIL sat_count got=%0d exp=255", out_count);
    end
  endtask

  task automatic test_mid_reset();
    bit p;
    logic [W-1:0] g, e;
    int seen;
    seen = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    rand_in();
    tick(p, g, e);
    rand_in();
    tick(p, g, e);
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL mr_two in_ready=%b valid=%b exp 0/1", in_ready, out_valid);
    end
    rst = 1'b1;
    out_ready = 1'b1;
    tick(p, g, e);
    sb.delete();
    total++;
    if (out_valid !== 1'b0 || out_count !== '0 || out_c !== '0) begin
      bad++;
      $display("FAIL mr_reset valid=%b cnt=%0d c=%h exp 0/0/0",
               out_valid, out_count, out_c);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(p, g, e);
      if (p || out_valid !== 1'b0) seen++;
    end
    total++;
    if (seen != 0 || out_count !== '0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mr_after ghost=%0d cnt=%0d in_ready=%b exp 0/0/1",
               seen, out_count, in_ready);
    end
  endtask

`ifdef LANE_COMBINE_PIPE_PARITY_EN
  task automatic test_parity();
    bit p;
    logic [W-1:0] g, e;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_a = {12'h123, 12'hFFE, 12'h000};
    in_b = {12'h456, 12'hFF3, 12'h000};
    in_mask = 3'b011;
    tick(p, g, e);
    in_a = {12'h000, 12'h000, 12'hFFE};
    in_b = {12'h000, 12'h000, 12'hFF3};
    in_mask = 3'b001;
    tick(p, g, e);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(p, g, e);
      total++;
      if (out_parity !== 3'b010 || out_c !== 36'h000_001_FFF) begin
        bad++;
        $display("FAIL par_stall par=%b c=%h exp 010/%h",
                 out_parity, out_c, 36'h000_001_FFF);
      end
    end
    out_ready = 1'b1;
    tick(p, g, e);
    total++;
    if (!p || g !== e || out_parity !== 3'b001 || out_c !== 36'h000_000_001) begin
      bad++;
      $display("FAIL par_second par=%b c=%h exp 001/%h",
               out_parity, out_c, 36'h000_000_001);
    end
    tick(p, g, e);
  endtask
`endif

  initial begin
    test_reset();
    test_function();
    test_mask();
    test_backpressure();
    test_saturation();
    test_mid_reset();
`ifdef LANE_COMBINE_PIPE_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
